// File: rtl/generic_sram_line_arbiter.sv
// Round-robin arbiter sharing one single-port line SRAM between requesters A and B.
// Optional power-up clearing sweep enabled by defining GENERIC_SRAM_LINE_ARB_INIT_EN.
module generic_sram_line_arbiter #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 7,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_a_valid,
  input  logic                     i_a_write,
  input  logic [ADDRESS_WIDTH-1:0] i_a_address,
  input  logic [DATA_WIDTH-1:0]    i_a_wdata,
  output logic                     o_a_ready,
  input  logic                     i_b_valid,
  input  logic                     i_b_write,
  input  logic [ADDRESS_WIDTH-1:0] i_b_address,
  input  logic [DATA_WIDTH-1:0]    i_b_wdata,
  output logic                     o_b_ready,
  output logic                     o_rd_valid,
  output logic                     o_rd_id,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic [ADDRESS_WIDTH-1:0] o_sram_address,
  output logic [DATA_WIDTH-1:0]    o_sram_wdata,
  output logic                     o_sram_we,
  input  logic [DATA_WIDTH-1:0]    i_sram_rdata,
  output logic                     o_init_done
);

  logic                     init_done_s;
  logic                     init_active_s;
  logic [ADDRESS_WIDTH-1:0] sweep_address_s;

`ifdef GENERIC_SRAM_LINE_ARB_INIT_EN
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = {ADDRESS_WIDTH{1'b1}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [ADDRESS_WIDTH-1:0] sweep_r;
  logic [ADDRESS_WIDTH-1:0] sweep_next_s;

  // Init FSM state and sweep counter registers; reset restarts the sweep.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_INIT;
      sweep_r <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      sweep_r <= sweep_next_s;
    end
  end

  // Init FSM next state: one address per cycle, then hand over to arbitration.
  always_comb begin
    state_next_s = state_r;
    sweep_next_s = sweep_r;
    case (state_r)
      ST_INIT: begin
        sweep_next_s = sweep_r + ADDRESS_ONE;
        if (sweep_r == LAST_ADDRESS) begin
          state_next_s = ST_ARB;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_ARB: begin
        state_next_s = ST_ARB;
        sweep_next_s = {ADDRESS_WIDTH{1'b0}};
      end
      default: begin
        state_next_s = ST_INIT;
        sweep_next_s = {ADDRESS_WIDTH{1'b0}};
      end
    endcase
  end

  assign init_active_s   = (state_r == ST_INIT);
  assign init_done_s     = (state_r == ST_ARB);
  assign sweep_address_s = sweep_r;
`else
  assign init_active_s   = 1'b0;
  assign init_done_s     = 1'b1;
  assign sweep_address_s = {ADDRESS_WIDTH{1'b0}};
`endif

  logic                     last_b_r;
  logic                     arb_en_s;
  logic                     grant_a_s;
  logic                     grant_b_s;
  logic                     rd_push_s;
  logic                     rd_push_id_s;
  logic [ADDRESS_WIDTH-1:0] address_s;
  logic [ADDRESS_WIDTH-1:0] address_hold_r;
  logic [DATA_WIDTH-1:0]    wdata_s;
  logic [DATA_WIDTH-1:0]    wdata_hold_r;
  logic                     we_s;
  logic [READ_LATENCY-1:0]  rd_valid_pipe_r;
  logic [READ_LATENCY-1:0]  rd_id_pipe_r;

  // On a tie the requester that did not win last time gets the port.
  assign arb_en_s  = init_done_s & ~i_reset;
  assign grant_a_s = arb_en_s & i_a_valid & (~i_b_valid | last_b_r);
  assign grant_b_s = arb_en_s & i_b_valid & (~i_a_valid | ~last_b_r);

  assign rd_push_s    = (grant_a_s & ~i_a_write) | (grant_b_s & ~i_b_write);
  assign rd_push_id_s = grant_b_s & ~i_b_write;

  // SRAM port mux: winner's fields, else init sweep, else hold the last value.
  always_comb begin
    address_s = address_hold_r;
    wdata_s   = wdata_hold_r;
    we_s      = 1'b0;
    if (i_reset) begin
      address_s = {ADDRESS_WIDTH{1'b0}};
      wdata_s   = {DATA_WIDTH{1'b0}};
      we_s      = 1'b0;
    end else if (grant_a_s) begin
      address_s = i_a_address;
      wdata_s   = i_a_wdata;
      we_s      = i_a_write;
    end else if (grant_b_s) begin
      address_s = i_b_address;
      wdata_s   = i_b_wdata;
      we_s      = i_b_write;
    end else if (init_active_s) begin
      address_s = sweep_address_s;
      wdata_s   = {DATA_WIDTH{1'b0}};
      we_s      = 1'b1;
    end else begin
      address_s = address_hold_r;
      wdata_s   = wdata_hold_r;
      we_s      = 1'b0;
    end
  end

  // Last-grant pointer and SRAM field hold registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_b_r       <= 1'b1;
      address_hold_r <= {ADDRESS_WIDTH{1'b0}};
      wdata_hold_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      if (grant_a_s) begin
        last_b_r <= 1'b0;
      end else if (grant_b_s) begin
        last_b_r <= 1'b1;
      end else begin
        last_b_r <= last_b_r;
      end
      address_hold_r <= address_s;
      wdata_hold_r   <= wdata_s;
    end
  end

  // Read tag pipe, aligned with the SRAM read latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_valid_pipe_r <= {READ_LATENCY{1'b0}};
      rd_id_pipe_r    <= {READ_LATENCY{1'b0}};
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        rd_valid_pipe_r[i] <= rd_valid_pipe_r[i-1];
        rd_id_pipe_r[i]    <= rd_id_pipe_r[i-1];
      end
      rd_valid_pipe_r[0] <= rd_push_s;
      rd_id_pipe_r[0]    <= rd_push_id_s;
    end
  end

  assign o_a_ready      = grant_a_s;
  assign o_b_ready      = grant_b_s;
  assign o_sram_address = address_s;
  assign o_sram_wdata   = wdata_s;
  assign o_sram_we      = we_s;
  assign o_rd_valid     = rd_valid_pipe_r[READ_LATENCY-1] & ~i_reset;
  assign o_rd_id        = rd_id_pipe_r[READ_LATENCY-1] & ~i_reset;
  assign o_rd_data      = i_sram_rdata;
  assign o_init_done    = init_done_s;

endmodule

// File: tb/tb_generic_sram_line_arbiter.sv
// Directed bench for generic_sram_line_arbiter with a behavioural 2-cycle NEW_DATA SRAM.
// Adapts to builds with or without the init sweep by measuring the sweep length.
module tb_generic_sram_line_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RL = 2;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_a_valid, i_a_write;
  logic [AW-1:0] i_a_address;
  logic [DW-1:0] i_a_wdata;
  logic          o_a_ready;
  logic          i_b_valid, i_b_write;
  logic [AW-1:0] i_b_address;
  logic [DW-1:0] i_b_wdata;
  logic          o_b_ready;
  logic          o_rd_valid, o_rd_id;
  logic [DW-1:0] o_rd_data;
  logic [AW-1:0] o_sram_address;
  logic [DW-1:0] o_sram_wdata;
  logic          o_sram_we;
  logic [DW-1:0] i_sram_rdata;
  logic          o_init_done;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q1, q2;

  int n_tests = 0;
  int n_fail  = 0;
  int init_cycles;
  int init_cycles2;
  logic [DW-1:0] exp_a, exp_b;

  generic_sram_line_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_valid(i_a_valid), .i_a_write(i_a_write), .i_a_address(i_a_address),
    .i_a_wdata(i_a_wdata), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_write(i_b_write), .i_b_address(i_b_address),
    .i_b_wdata(i_b_wdata), .o_b_ready(o_b_ready),
    .o_rd_valid(o_rd_valid), .o_rd_id(o_rd_id), .o_rd_data(o_rd_data),
    .o_sram_address(o_sram_address), .o_sram_wdata(o_sram_wdata), .o_sram_we(o_sram_we),
    .i_sram_rdata(i_sram_rdata), .o_init_done(o_init_done)
  );

  always #5 i_clk = ~i_clk;

  // Single-port SRAM, registered q, write-first on a same-cycle access.
  always @(posedge i_clk) begin
    if (o_sram_we) mem[o_sram_address] <= o_sram_wdata;
    q1 <= o_sram_we ? o_sram_wdata : mem[o_sram_address];
    q2 <= q1;
  end
  assign i_sram_rdata = q2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_done(output int cycles);
    int cnt;
    cnt = 0;
    @(negedge i_clk);
    while (o_init_done !== 1'b1 && cnt < 20) begin
      chk("init_a_ready", o_a_ready, 0);
      chk("init_b_ready", o_b_ready, 0);
      chk("init_we", o_sram_we, 1);
      chk("init_addr", o_sram_address, cnt);
      chk("init_wdata", o_sram_wdata, 0);
      chk("init_rd_valid", o_rd_valid, 0);
      cnt++;
      cyc();
      @(negedge i_clk);
    end
    chk("init_len", (cnt == 0) || (cnt == (1 << AW)), 1);
    chk("init_done", o_init_done, 1);
    cycles = cnt;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    i_reset = 1'b1;
    i_a_valid = 1'b1; i_a_write = 1'b1; i_a_address = 3'd1; i_a_wdata = 32'h0000_1111;
    i_b_valid = 1'b1; i_b_write = 1'b1; i_b_address = 3'd2; i_b_wdata = 32'h0000_2222;

    // Reset values, with both requesters valid
    @(negedge i_clk);
    chk("rst_a_ready", o_a_ready, 0);
    chk("rst_b_ready", o_b_ready, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_id", o_rd_id, 0);
    chk("rst_we", o_sram_we, 0);
    chk("rst_addr", o_sram_address, 0);
    chk("rst_wdata", o_sram_wdata, 0);
    cyc();
    i_reset = 1'b0;

    // Requesters held valid through any init sweep; first tie goes to A
    wait_done(init_cycles);
    chk("tie0_a_ready", o_a_ready, 1);
    chk("tie0_b_ready", o_b_ready, 0);
    chk("tie0_we", o_sram_we, 1);
    chk("tie0_addr", o_sram_address, 1);
    chk("tie0_wdata", o_sram_wdata, 32'h0000_1111);
    cyc();
    i_a_valid = 1'b0; i_b_valid = 1'b0;

    // Only B valid for three cycles, then a tie after B won last
    i_b_valid = 1'b1; i_b_address = 3'd2; i_b_wdata = 32'h0000_2222;
    @(negedge i_clk); chk("bonly1_b", o_b_ready, 1); chk("bonly1_a", o_a_ready, 0);
    cyc();
    i_b_address = 3'd4; i_b_wdata = 32'h0000_4444;
    @(negedge i_clk); chk("bonly2_b", o_b_ready, 1); chk("bonly2_addr", o_sram_address, 4);
    cyc();
    i_b_address = 3'd7; i_b_wdata = 32'h0000_7777;
    @(negedge i_clk); chk("bonly3_b", o_b_ready, 1); chk("bonly3_we", o_sram_we, 1);
    cyc();
    i_a_valid = 1'b1; i_a_write = 1'b1; i_a_address = 3'd6; i_a_wdata = 32'h0000_6666;
    @(negedge i_clk); chk("tie1_a", o_a_ready, 1); chk("tie1_b", o_b_ready, 0);
    cyc();
    i_a_valid = 1'b0; i_b_valid = 1'b0;

    // Idle: no write, address and data hold
    @(negedge i_clk);
    chk("idle_we", o_sram_we, 0);
    chk("idle_addr", o_sram_address, 6);
    chk("idle_wdata", o_sram_wdata, 32'h0000_6666);
    chk("idle_a_ready", o_a_ready, 0);
    cyc();

    // Write then read the same address on consecutive cycles
    i_a_valid = 1'b1; i_a_write = 1'b1; i_a_address = 3'd5; i_a_wdata = 32'hAAAA_AAAA;
    @(negedge i_clk); chk("wr5_ready", o_a_ready, 1); chk("wr5_we", o_sram_we, 1);
    cyc();
    i_a_write = 1'b0;
    @(negedge i_clk); chk("rd5_ready", o_a_ready, 1); chk("rd5_we", o_sram_we, 0);
    cyc();
    i_a_valid = 1'b0;
    @(negedge i_clk); chk("rd5_lat1_valid", o_rd_valid, 0);
    cyc();
    @(negedge i_clk);
    chk("rd5_valid", o_rd_valid, 1);
    chk("rd5_id", o_rd_id, 0);
    chk("rd5_data", o_rd_data, 32'hAAAA_AAAA);
    cyc();
    @(negedge i_clk); chk("rd5_pulse", o_rd_valid, 0);
    cyc();

    // Read accepted, then reset: the response is discarded
    i_a_valid = 1'b1; i_a_write = 1'b0; i_a_address = 3'd5;
    @(negedge i_clk); chk("rdrst_ready", o_a_ready, 1);
    cyc();
    i_reset = 1'b1; i_b_valid = 1'b1; i_b_write = 1'b0;
    @(negedge i_clk);
    chk("inrst_a_ready", o_a_ready, 0);
    chk("inrst_b_ready", o_b_ready, 0);
    chk("inrst_rd_valid", o_rd_valid, 0);
    cyc();
    i_reset = 1'b0; i_a_valid = 1'b0; i_b_valid = 1'b0;
    wait_done(init_cycles2);
    chk("init_len_repeat", init_cycles2, init_cycles);
    for (int k = 0; k < 4; k++) begin
      chk("postrst_rd_valid", o_rd_valid, 0);
      cyc();
      @(negedge i_clk);
    end
    cyc();

    // Both valid reads: grants alternate A,B,A,B; responses follow in order
    exp_a = (init_cycles != 0) ? 32'h0 : 32'hC0DE_0003;
    exp_b = (init_cycles != 0) ? 32'h0 : 32'h0000_4444;
    i_a_valid = 1'b1; i_a_write = 1'b0; i_a_address = 3'd3;
    i_b_valid = 1'b1; i_b_write = 1'b0; i_b_address = 3'd4;
    @(negedge i_clk); chk("rr0_a", o_a_ready, 1); chk("rr0_b", o_b_ready, 0);
    cyc();
    @(negedge i_clk); chk("rr1_a", o_a_ready, 0); chk("rr1_b", o_b_ready, 1);
    chk("rr1_rd_valid", o_rd_valid, 0);
    cyc();
    @(negedge i_clk); chk("rr2_a", o_a_ready, 1); chk("rr2_b", o_b_ready, 0);
    chk("rr2_rd_valid", o_rd_valid, 1); chk("rr2_id", o_rd_id, 0); chk("rr2_data", o_rd_data, exp_a);
    cyc();
    @(negedge i_clk); chk("rr3_a", o_a_ready, 0); chk("rr3_b", o_b_ready, 1);
    chk("rr3_rd_valid", o_rd_valid, 1); chk("rr3_id", o_rd_id, 1); chk("rr3_data", o_rd_data, exp_b);
    cyc();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    @(negedge i_clk);
    chk("rr4_rd_valid", o_rd_valid, 1); chk("rr4_id", o_rd_id, 0); chk("rr4_data", o_rd_data, exp_a);
    cyc();
    @(negedge i_clk);
    chk("rr5_rd_valid", o_rd_valid, 1); chk("rr5_id", o_rd_id, 1); chk("rr5_data", o_rd_data, exp_b);
    cyc();
    @(negedge i_clk); chk("rr6_rd_valid", o_rd_valid, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
